// File: rtl/ctrl_regs_param.sv
// ctrl_regs_param: parametrised per-slave control register file.
//
// Sits between the register command interface and the arbiter/formatter. It holds
// per-slave enable/priority/length, a registered copy of per-slave FIFO availability,
// a one-shot configuration lock and a saturating read-clear error counter.
//
// Optional feature macro: CTRL_REGS_PARAM_SHADOW_EN
//   defined   : CTRL writes land in shadow registers; a write to COMMIT (0x88) copies
//               all shadows to the outputs at once.
//   undefined : CTRL writes drive the outputs directly; 0x88 is unmapped.
//
// Ports:
//   clk_i        clock, all state on rising edge
//   rstn_i       asynchronous active-low reset
//   cmd_i        command: 00 idle, 01 read, 10 write, 11 idle
//   cmd_addr_i   byte address (word aligned)
//   cmd_data_i   write data
//   cmd_data_o   registered read data, holds until the next read
//   slv_avail_i  per-slave availability, slave k at [k*AVAIL_W +: AVAIL_W]
//   slv_len_o    per-slave packet length
//   slv_prio_o   per-slave priority
//   slv_en_o     per-slave enable
module ctrl_regs_param #(
    parameter int unsigned NUM_SLV = 3,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LEN_W   = 3,
    parameter int unsigned PRIO_W  = 2,
    parameter int unsigned AVAIL_W = 8
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic [1:0]                 cmd_i,
    input  logic [ADDR_W-1:0]          cmd_addr_i,
    input  logic [DATA_W-1:0]          cmd_data_i,
    output logic [DATA_W-1:0]          cmd_data_o,
    input  logic [NUM_SLV*AVAIL_W-1:0] slv_avail_i,
    output logic [NUM_SLV*LEN_W-1:0]   slv_len_o,
    output logic [NUM_SLV*PRIO_W-1:0]  slv_prio_o,
    output logic [NUM_SLV-1:0]         slv_en_o
);

    localparam logic [1:0] CmdRead  = 2'b01;
    localparam logic [1:0] CmdWrite = 2'b10;

    // Programmer-visible CTRL registers (the shadows when the shadow feature is built)
    logic [NUM_SLV-1:0]         cfg_en_q, cfg_en_d;
    logic [NUM_SLV*PRIO_W-1:0]  cfg_prio_q, cfg_prio_d;
    logic [NUM_SLV*LEN_W-1:0]   cfg_len_q, cfg_len_d;

    logic [NUM_SLV*AVAIL_W-1:0] stat_q;
    logic                       lock_q, lock_d;
    logic [7:0]                 err_q, err_d;
    logic [DATA_W-1:0]          rdata_q, rdata_d;

    logic       is_rd, is_wr, aligned;
    logic       ctrl_hit, stat_hit, lock_hit, err_hit;
    logic [3:0] idx;
    logic       wr_err;

    assign is_rd   = (cmd_i == CmdRead);
    assign is_wr   = (cmd_i == CmdWrite);
    assign aligned = (cmd_addr_i[1:0] == 2'b00);
    assign idx     = cmd_addr_i[5:2];

    assign ctrl_hit = aligned && (cmd_addr_i < ADDR_W'(4 * NUM_SLV));
    assign stat_hit = aligned && (cmd_addr_i >= ADDR_W'(32'h40))
                              && (cmd_addr_i < ADDR_W'(32'h40 + 4 * NUM_SLV));
    assign lock_hit = (cmd_addr_i == ADDR_W'(32'h80));
    assign err_hit  = (cmd_addr_i == ADDR_W'(32'h84));

`ifdef CTRL_REGS_PARAM_SHADOW_EN
    logic commit_hit, commit_ok;
    assign commit_hit = (cmd_addr_i == ADDR_W'(32'h88));
`endif

    always_comb begin
        cfg_en_d   = cfg_en_q;
        cfg_prio_d = cfg_prio_q;
        cfg_len_d  = cfg_len_q;
        lock_d     = lock_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        wr_err     = 1'b0;
`ifdef CTRL_REGS_PARAM_SHADOW_EN
        commit_ok  = 1'b0;
`endif
        if (is_wr) begin
            if (ctrl_hit) begin
                if (lock_q) begin
                    wr_err = 1'b1;
                end else begin
                    for (int k = 0; k < int'(NUM_SLV); k++) begin
                        if (idx == 4'(k)) begin
                            cfg_en_d[k]                  = cmd_data_i[0];
                            cfg_prio_d[k*PRIO_W +: PRIO_W] = cmd_data_i[PRIO_W:1];
                            cfg_len_d[k*LEN_W +: LEN_W]    = cmd_data_i[PRIO_W+LEN_W:PRIO_W+1];
                        end
                    end
                end
            end else if (lock_hit) begin
                // Set-only: writing 0 is legal and does nothing
                if (cmd_data_i[0]) lock_d = 1'b1;
            end
`ifdef CTRL_REGS_PARAM_SHADOW_EN
            else if (commit_hit) begin
                if (lock_q) wr_err = 1'b1;
                else        commit_ok = 1'b1;
            end
`endif
            else begin
                // STAT, ERR and anything unmapped or misaligned
                wr_err = 1'b1;
            end
        end else if (is_rd) begin
            rdata_d = '0;
            for (int k = 0; k < int'(NUM_SLV); k++) begin
                if (ctrl_hit && idx == 4'(k)) begin
                    rdata_d[0]                   = cfg_en_q[k];
                    rdata_d[PRIO_W:1]            = cfg_prio_q[k*PRIO_W +: PRIO_W];
                    rdata_d[PRIO_W+LEN_W:PRIO_W+1] = cfg_len_q[k*LEN_W +: LEN_W];
                end
                if (stat_hit && idx == 4'(k)) begin
                    rdata_d[AVAIL_W-1:0] = stat_q[k*AVAIL_W +: AVAIL_W];
                end
            end
            if (lock_hit) rdata_d[0] = lock_q;
            if (err_hit) begin
                rdata_d[7:0] = err_q;
                err_d        = 8'h00;
            end
        end

        if (wr_err && (err_q != 8'hFF)) err_d = err_q + 8'd1;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cfg_en_q   <= '1;
            cfg_prio_q <= '1;
            cfg_len_q  <= '0;
            stat_q     <= '0;
            lock_q     <= 1'b0;
            err_q      <= 8'h00;
            rdata_q    <= '0;
        end else begin
            cfg_en_q   <= cfg_en_d;
            cfg_prio_q <= cfg_prio_d;
            cfg_len_q  <= cfg_len_d;
            stat_q     <= slv_avail_i;
            lock_q     <= lock_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

`ifdef CTRL_REGS_PARAM_SHADOW_EN
    logic [NUM_SLV-1:0]        out_en_q;
    logic [NUM_SLV*PRIO_W-1:0] out_prio_q;
    logic [NUM_SLV*LEN_W-1:0]  out_len_q;

    // Shadow writes and COMMIT never share a cycle, so copying the _q values is atomic
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            out_en_q   <= '1;
            out_prio_q <= '1;
            out_len_q  <= '0;
        end else if (commit_ok) begin
            out_en_q   <= cfg_en_q;
            out_prio_q <= cfg_prio_q;
            out_len_q  <= cfg_len_q;
        end
    end

    assign slv_en_o   = out_en_q;
    assign slv_prio_o = out_prio_q;
    assign slv_len_o  = out_len_q;
`else
    assign slv_en_o   = cfg_en_q;
    assign slv_prio_o = cfg_prio_q;
    assign slv_len_o  = cfg_len_q;
`endif

    assign cmd_data_o = rdata_q;

endmodule

// File: tb/tb_ctrl_regs_param.sv
module tb_ctrl_regs_param;

    localparam int NUM = 3;

    logic        clk;
    logic        rstn;
    logic [1:0]  cmd;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [23:0] slv_avail;
    logic [8:0]  slv_len;
    logic [5:0]  slv_prio;
    logic [2:0]  slv_en;

    int checks = 0;
    int errors = 0;

    // Scoreboard of expected read data, pushed when a read is issued
    logic [31:0] exp_q[$];

    // Reference model: visible CTRL view and the values driving the outputs
    logic [5:0] m_ctrl[NUM];
    logic [5:0] m_out[NUM];

    ctrl_regs_param dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .cmd_i       (cmd),
        .cmd_addr_i  (addr),
        .cmd_data_i  (wdata),
        .cmd_data_o  (rdata),
        .slv_avail_i (slv_avail),
        .slv_len_o   (slv_len),
        .slv_prio_o  (slv_prio),
        .slv_en_o    (slv_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] f_en();
        logic [2:0] v;
        for (int k = 0; k < NUM; k++) v[k] = m_out[k][0];
        return v;
    endfunction

    function automatic logic [5:0] f_prio();
        logic [5:0] v;
        for (int k = 0; k < NUM; k++) v[k*2 +: 2] = m_out[k][2:1];
        return v;
    endfunction

    function automatic logic [8:0] f_len();
        logic [8:0] v;
        for (int k = 0; k < NUM; k++) v[k*3 +: 3] = m_out[k][5:3];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NUM; k++) begin
            m_ctrl[k] = 6'h07;
            m_out[k]  = 6'h07;
        end
    endtask

    // Model side of a successful CTRL write (outputs follow only without shadows)
    task automatic model_ctrl(input int k, input logic [31:0] d);
        m_ctrl[k] = d[5:0];
`ifndef CTRL_REGS_PARAM_SHADOW_EN
        m_out[k] = d[5:0];
`endif
    endtask

    task automatic model_commit();
        for (int k = 0; k < NUM; k++) m_out[k] = m_ctrl[k];
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        cmd = 2'b10; addr = a; wdata = d;
        @(posedge clk);
        #1;
        cmd = 2'b00;
    endtask

    task automatic do_read(input logic [7:0] a, input logic [31:0] e, input string name);
        logic [31:0] want;
        @(negedge clk);
        cmd = 2'b01; addr = a;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cmd = 2'b00;
        want = exp_q.pop_front();
        checks++;
        if (rdata !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, rdata, want);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; cmd = 2'b00; addr = '0; wdata = '0; slv_avail = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got %h expected 0", rdata);
        end
        @(negedge clk);
        rstn = 1'b1;
        #1;
        checks++;
        if (slv_en !== 3'b111) begin
            errors++; $display("FAIL reset_en: got %b expected 111", slv_en);
        end
        checks++;
        if (slv_prio !== 6'h3F) begin
            errors++; $display("FAIL reset_prio: got %h expected 3f", slv_prio);
        end
        checks++;
        if (slv_len !== 9'h0) begin
            errors++; $display("FAIL reset_len: got %h expected 0", slv_len);
        end
        for (int k = 0; k < NUM; k++) do_read(8'(4 * k), 32'h7, "reset_ctrl");
        do_read(8'h80, 32'h0, "reset_lock");
        do_read(8'h84, 32'h0, "reset_err");
    endtask

    task automatic test_write();
        do_write(8'h04, 32'h2B);
        model_ctrl(1, 32'h2B);
        checks++;
        if (slv_en !== f_en() || slv_prio !== f_prio() || slv_len !== f_len()) begin
            errors++;
            $display("FAIL write_out: got en=%b prio=%h len=%h expected en=%b prio=%h len=%h",
                     slv_en, slv_prio, slv_len, f_en(), f_prio(), f_len());
        end
        do_read(8'h04, 32'h2B, "write_rd1");
        // Reserved upper bits must be dropped
        do_write(8'h00, 32'hFFFF_FF95);
        model_ctrl(0, 32'hFFFF_FF95);
        do_read(8'h00, 32'h15, "write_reserved");
        do_write(8'h08, 32'h3E);
        model_ctrl(2, 32'h3E);
        do_read(8'h08, 32'h3E, "write_rd2");
`ifdef CTRL_REGS_PARAM_SHADOW_EN
        do_write(8'h88, 32'h0);
        model_commit();
`endif
        checks++;
        if (slv_en !== f_en() || slv_prio !== f_prio() || slv_len !== f_len()) begin
            errors++;
            $display("FAIL write_all: got en=%b prio=%h len=%h expected en=%b prio=%h len=%h",
                     slv_en, slv_prio, slv_len, f_en(), f_prio(), f_len());
        end
    endtask

    task automatic test_stat_err();
        logic [31:0] want;
        @(negedge clk);
        slv_avail = {8'h20, 8'h11, 8'h05};
        do_read(8'h48, 32'h20, "stat_slv2");
        do_read(8'h40, 32'h05, "stat_slv0");
        // Copy lags the input: a read in the same cycle as a change sees the old value
        @(negedge clk);
        slv_avail[23:16] = 8'h33;
        cmd = 2'b01; addr = 8'h48;
        exp_q.push_back(32'h20);
        @(posedge clk);
        #1;
        cmd = 2'b00;
        want = exp_q.pop_front();
        checks++;
        if (rdata !== want) begin
            errors++; $display("FAIL stat_lag: got %h expected %h", rdata, want);
        end
        do_read(8'h48, 32'h33, "stat_new");
        do_read(8'h01, 32'h0, "rd_misaligned");
        do_read(8'hFC, 32'h0, "rd_unmapped");
        do_write(8'h48, 32'hFF);
        do_write(8'h0C, 32'h00);
        do_write(8'h02, 32'h00);
        do_read(8'h84, 32'h3, "err_count");
        do_read(8'h84, 32'h0, "err_cleared");
        checks++;
        if (slv_en !== f_en() || slv_len !== f_len()) begin
            errors++; $display("FAIL err_nochange: got en=%b len=%h expected en=%b len=%h",
                               slv_en, slv_len, f_en(), f_len());
        end
    endtask

    task automatic test_shadow();
        do_write(8'h00, 32'h0);
        model_ctrl(0, 32'h0);
        checks++;
        if (slv_en !== f_en()) begin
            errors++; $display("FAIL shadow_hold: got %b expected %b", slv_en, f_en());
        end
        do_read(8'h00, 32'h0, "shadow_rd");
        do_write(8'h88, 32'h1234);
`ifdef CTRL_REGS_PARAM_SHADOW_EN
        model_commit();
        do_read(8'h84, 32'h0, "commit_noerr");
`else
        do_read(8'h84, 32'h1, "addr88_err");
`endif
        checks++;
        if (slv_en !== f_en() || slv_en[0] !== 1'b0) begin
            errors++; $display("FAIL commit_en: got %b expected %b", slv_en, f_en());
        end
    endtask

    task automatic test_lock();
        do_write(8'h00, 32'h15);
        model_ctrl(0, 32'h15);
`ifdef CTRL_REGS_PARAM_SHADOW_EN
        do_write(8'h88, 32'h0);
        model_commit();
`endif
        do_write(8'h80, 32'h1);
        do_read(8'h80, 32'h1, "lock_set");
        do_write(8'h00, 32'h00);
        checks++;
        if (slv_en[0] !== 1'b1) begin
            errors++; $display("FAIL lock_blocks: got %b expected 1", slv_en[0]);
        end
        do_read(8'h00, 32'h15, "lock_ctrl_rd");
        do_read(8'h84, 32'h1, "lock_err");
        do_write(8'h80, 32'h0);
        do_write(8'h80, 32'h1);
        do_read(8'h80, 32'h1, "lock_sticky");
        do_write(8'h88, 32'h0);
        do_read(8'h84, 32'h1, "lock_commit_err");
        // Asynchronous reset in the middle of a write cycle
        @(negedge clk);
        cmd = 2'b10; addr = 8'h04; wdata = 32'h0;
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        checks++;
        if (slv_en !== 3'b111 || slv_prio !== 6'h3F || slv_len !== 9'h0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: got en=%b prio=%h len=%h rd=%h expected 111/3f/0/0",
                     slv_en, slv_prio, slv_len, rdata);
        end
        @(posedge clk);
        @(negedge clk);
        cmd = 2'b00;
        rstn = 1'b1;
        do_read(8'h80, 32'h0, "lock_cleared");
        do_read(8'h04, 32'h7, "reset_discard");
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) do_write(8'hFC, 32'h0);
        do_read(8'h84, 32'hFF, "err_sat");
        do_read(8'h84, 32'h0, "err_sat_clr");
    endtask

    task automatic test_back_to_back();
        do_write(8'h84, 32'h0);
        do_write(8'h40, 32'h0);
        do_write(8'h08, 32'h19);
        model_ctrl(2, 32'h19);
        do_read(8'h08, 32'h19, "b2b_ctrl2");
        do_read(8'h84, 32'h2, "b2b_err_n");
        do_read(8'h84, 32'h0, "b2b_err_0");
        do_read(8'h44, 32'h11, "b2b_stat1");
        do_read(8'h00, 32'h07, "b2b_ctrl0");
        // Read data holds while idle
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rdata !== 32'h07) begin
            errors++; $display("FAIL rd_hold: got %h expected 7", rdata);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_stat_err();
        test_shadow();
        test_lock();
        test_saturate();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
